edge_rate_meter: RTL and testbench

EDGE_RATE_METER -- requirements
Module: edge_rate_meter

---
 rtl/edge_rate_meter_pkg.sv | 15 +
 rtl/edge_rate_meter_gate_timer.sv | 31 +++
 rtl/edge_rate_meter.sv | 119 +++++++++++
 tb/tb_edge_rate_meter.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/edge_rate_meter_pkg.sv
// Shared definitions for the edge rate meter.
// State encodings and the window-timer compare width.
package edge_rate_meter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2
    } erm_state_t;

    function automatic int gate_width(input int gate_cycles);
        return (gate_cycles < 2) ? 1 : $clog2(gate_cycles);
    endfunction

endpackage

// File: rtl/edge_rate_meter_gate_timer.sv
// Measurement window timer.
// window_end pulses on the last cycle of every GATE_CYCLES window.
module gate_timer
    import edge_rate_meter_pkg::*;
#(
    parameter int GATE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    output logic window_end
);

    localparam int TW = gate_width(GATE_CYCLES);
    localparam logic [TW-1:0] LAST = TW'(GATE_CYCLES - 1);

    logic [TW-1:0] timer;

    assign window_end = (timer == LAST);

    always_ff @(posedge clk) begin
        if (rst || start) begin
            timer <= '0;
        end else if (window_end) begin
            timer <= '0;
        end else begin
            timer <= timer + 1'b1;
        end
    end

endmodule

// File: rtl/edge_rate_meter.sv
// Edge rate meter: differences a running edge count over fixed
// windows and tracks min/max/stall statistics of the resulting rates.
module edge_rate_meter
    import edge_rate_meter_pkg::*;
#(
    parameter int COUNTER_WIDTH = 16,
    parameter int GATE_CYCLES   = 1000000,
    parameter int STALL_WINDOWS = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enable,
    input  logic                     clear_stats,
    input  logic [COUNTER_WIDTH-1:0] counter_in,
    output logic [COUNTER_WIDTH-1:0] rate_out,
    output logic                     rate_valid,
    output logic [COUNTER_WIDTH-1:0] rate_min,
    output logic [COUNTER_WIDTH-1:0] rate_max,
    output logic                     stats_valid,
    output logic                     stall
);

    localparam int ZW = $clog2(STALL_WINDOWS + 1);
    localparam logic [ZW-1:0] ZMAX = ZW'(STALL_WINDOWS);

    erm_state_t               state;
    logic [COUNTER_WIDTH-1:0] baseline;
    logic [COUNTER_WIDTH-1:0] delta;
    logic [ZW-1:0]            zero_cnt;
    logic [ZW-1:0]            zero_nxt;
    logic                     window_end;
    logic                     timer_start;

    // Timer is held at zero in IDLE so PRIME always gets a full window
    assign timer_start = (state == IDLE);

    gate_timer #(
        .GATE_CYCLES(GATE_CYCLES)
    ) u_gate_timer (
        .clk       (clk),
        .rst       (rst),
        .start     (timer_start),
        .window_end(window_end)
    );

    // Modular subtraction handles a single wrap of counter_in
    assign delta = counter_in - baseline;

    always_comb begin
        zero_nxt = '0;
        if (rate_out == '0) begin
            zero_nxt = (zero_cnt == ZMAX) ? zero_cnt : zero_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            baseline    <= '0;
            rate_out    <= '0;
            rate_valid  <= 1'b0;
            rate_min    <= '0;
            rate_max    <= '0;
            stats_valid <= 1'b0;
            stall       <= 1'b0;
            zero_cnt    <= '0;
        end else begin
            rate_valid <= 1'b0;

            unique case (state)
                IDLE: begin
                    if (enable) begin
                        state    <= PRIME;
                        baseline <= counter_in;
                    end
                end
                PRIME: begin
                    if (!enable) begin
                        state <= IDLE;
                    end else if (window_end) begin
                        state    <= RUN;
                        baseline <= counter_in;
                    end
                end
                RUN: begin
                    if (!enable) begin
                        state <= IDLE;
                    end else if (window_end) begin
                        rate_out   <= delta;
                        rate_valid <= 1'b1;
                        baseline   <= counter_in;
                    end
                end
                default: state <= IDLE;
            endcase

            // Stats consume the sample while rate_valid is high; clear wins
            if (clear_stats) begin
                rate_min    <= '0;
                rate_max    <= '0;
                stats_valid <= 1'b0;
                stall       <= 1'b0;
                zero_cnt    <= '0;
            end else if (rate_valid) begin
                if (!stats_valid) begin
                    rate_min <= rate_out;
                    rate_max <= rate_out;
                end else begin
                    if (rate_out < rate_min) rate_min <= rate_out;
                    if (rate_out > rate_max) rate_max <= rate_out;
                end
                stats_valid <= 1'b1;
                zero_cnt    <= zero_nxt;
                stall       <= (zero_nxt >= ZMAX);
            end
        end
    end

endmodule

// File: tb/tb_edge_rate_meter.sv
// Randomized bench for edge_rate_meter against a window/sample-list model.
// Small windows and an 8-bit counter exercise wraps, stalls and clears.
module tb_edge_rate_meter;

    localparam int CW = 8;
    localparam int G  = 20;
    localparam int SW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          enable;
    logic          clear_stats;
    logic [CW-1:0] counter_in;
    logic [CW-1:0] rate_out;
    logic          rate_valid;
    logic [CW-1:0] rate_min;
    logic [CW-1:0] rate_max;
    logic          stats_valid;
    logic          stall;

    always #5 clk = ~clk;

    edge_rate_meter #(
        .COUNTER_WIDTH(CW),
        .GATE_CYCLES  (G),
        .STALL_WINDOWS(SW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .clear_stats(clear_stats),
        .counter_in (counter_in),
        .rate_out   (rate_out),
        .rate_valid (rate_valid),
        .rate_min   (rate_min),
        .rate_max   (rate_max),
        .stats_valid(stats_valid),
        .stall      (stall)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t",
                      tag, got, exp, $time);
    endtask

    // Reference: cycle index since activation, snapshots at window ends,
    // and the list of samples accepted since the last clear.
    bit            m_active;
    int            m_cyc;
    logic [CW-1:0] m_snap;
    logic [CW-1:0] m_rate;
    bit            m_valid;
    logic [CW-1:0] m_q[$];

    task automatic model_step(input bit r, input bit en, input bit clr,
                              input logic [CW-1:0] cin);
        bit nv;
        nv = 1'b0;
        if (r) begin
            m_active = 1'b0;
            m_cyc    = 0;
            m_snap   = '0;
            m_rate   = '0;
            m_valid  = 1'b0;
            m_q.delete();
            return;
        end
        if (clr) m_q.delete();
        else if (m_valid) m_q.push_back(m_rate);
        if (!m_active) begin
            if (en) begin
                m_active = 1'b1;
                m_cyc    = 0;
            end
        end else if (!en) begin
            m_active = 1'b0;
        end else begin
            if (m_cyc % G == G - 1) begin
                // first window is the priming one and yields no sample
                if (m_cyc >= 2 * G - 1) begin
                    m_rate = cin - m_snap;
                    nv     = 1'b1;
                end
                m_snap = cin;
            end
            m_cyc++;
        end
        m_valid = nv;
    endtask

    task automatic compare_all();
        logic [CW-1:0] mn, mx;
        int tz;
        mn = '0;
        mx = '0;
        tz = 0;
        foreach (m_q[i]) begin
            if (i == 0 || m_q[i] < mn) mn = m_q[i];
            if (i == 0 || m_q[i] > mx) mx = m_q[i];
            tz = (m_q[i] == 0) ? tz + 1 : 0;
        end
        check("rate_out", rate_out, m_rate);
        check("rate_valid", rate_valid, m_valid);
        check("rate_min", rate_min, mn);
        check("rate_max", rate_max, mx);
        check("stats_valid", stats_valid, m_q.size() != 0);
        check("stall", stall, tz >= SW);
    endtask

    logic [CW-1:0] cnt;
    int            tcyc = 0;

    task automatic run(input int n, input int mode, input int clr_pct,
                       input int dis_pct, input bit clr_on_valid);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            tcyc++;
            case (mode)
                0: if (tcyc % 10 == 0) cnt = cnt + 8'd1;
                1: cnt = cnt + 8'($urandom_range(0, 3));
                3: if ($urandom_range(0, 99) < 8) cnt = cnt + 8'd1;
                default: ;
            endcase
            clear_stats = ($urandom_range(0, 99) < clr_pct) ||
                          (clr_on_valid && m_valid);
            if (dis_pct > 0) begin
                if (enable && $urandom_range(0, 99) < dis_pct) enable = 1'b0;
                else if (!enable && $urandom_range(0, 99) < 30) enable = 1'b1;
            end
            counter_in = cnt;
            @(posedge clk);
            model_step(rst, enable, clear_stats, counter_in);
            #1 compare_all();
        end
    endtask

    initial begin
        rst         = 1'b1;
        enable      = 1'b0;
        clear_stats = 1'b0;
        cnt         = '0;
        counter_in  = '0;
        run(3, 2, 0, 0, 0);
        rst = 1'b0;
        run(5, 2, 0, 0, 0);
        cnt    = 8'd250;
        enable = 1'b1;
        run(200, 0, 0, 0, 0);
        run(600, 1, 3, 0, 0);
        run(200, 2, 0, 0, 0);
        run(60, 3, 0, 0, 0);
        run(300, 1, 0, 0, 1);
        run(200, 1, 0, 0, 0);
        run(600, 1, 2, 2, 0);
        enable = 1'b1;
        run(100, 1, 0, 0, 0);
        rst    = 1'b1;
        run(2, 1, 100, 0, 0);
        rst = 1'b0;
        clear_stats = 1'b0;
        run(100, 1, 0, 0, 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
